// File: rtl/iob_bus_arbiter_if.sv
// Single IOb-style native bus port: request from the master side, response from the slave side.
// The arbiter takes two of these as master-facing ports and one as its slave-facing port.
interface iob_bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  avalid;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  rvalid;
    logic                  ready;

    modport master (
        output avalid, addr, wdata, wstrb,
        input  rdata, rvalid, ready
    );

    modport slave (
        input  avalid, addr, wdata, wstrb,
        output rdata, rvalid, ready
    );
endinterface

// File: rtl/iob_bus_arbiter.sv
// Two-master to one-slave IOb arbiter with round-robin or fixed priority.
// Reads hold the bus until the slave returns rvalid; writes complete on acceptance.
module iob_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cke_i,
    iob_bus_arbiter_if.slave  m0,
    iob_bus_arbiter_if.slave  m1,
    iob_bus_arbiter_if.master s
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_RD_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;

    logic [1:0]        req_avalid;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [DATA_W-1:0] req_wdata [2];
    logic [STRB_W-1:0] req_wstrb [2];

    logic       sel_valid;
    logic       sel_idx;
    logic       accept;
    logic       accept_read;
    logic [1:0] ready_vec;
    logic [1:0] rvalid_vec;

    assign req_avalid[0] = m0.avalid;
    assign req_avalid[1] = m1.avalid;
    assign req_addr[0]   = m0.addr;
    assign req_addr[1]   = m1.addr;
    assign req_wdata[0]  = m0.wdata;
    assign req_wdata[1]  = m1.wdata;
    assign req_wstrb[0]  = m0.wstrb;
    assign req_wstrb[1]  = m1.wstrb;

    // Selection only happens in IDLE; on a tie round-robin favours the master not granted last.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = 1'b0;
        if (state_q == ST_IDLE) begin
            case (req_avalid)
                2'b01: begin
                    sel_valid = 1'b1;
                    sel_idx   = 1'b0;
                end
                2'b10: begin
                    sel_valid = 1'b1;
                    sel_idx   = 1'b1;
                end
                2'b11: begin
                    sel_valid = 1'b1;
                    sel_idx   = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
                end
                default: begin
                    sel_valid = 1'b0;
                    sel_idx   = 1'b0;
                end
            endcase
        end
    end

    assign accept      = sel_valid & s.ready;
    assign accept_read = accept & (req_wstrb[sel_idx] == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        if (cke_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        last_grant_d = sel_idx;
                        if (accept_read) begin
                            owner_d = sel_idx;
                            state_d = ST_RD_WAIT;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (s.rvalid) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s.avalid = sel_valid;
        s.addr   = sel_valid ? req_addr[sel_idx]  : '0;
        s.wdata  = sel_valid ? req_wdata[sel_idx] : '0;
        s.wstrb  = sel_valid ? req_wstrb[sel_idx] : '0;
    end

    // Ready follows the slave only for the selected master; rvalid only reaches the read owner.
    for (genvar gi = 0; gi < 2; gi++) begin : g_master_resp
        assign ready_vec[gi]  = sel_valid & (sel_idx == 1'(gi)) & s.ready;
        assign rvalid_vec[gi] = (state_q == ST_RD_WAIT) & (owner_q == 1'(gi)) & s.rvalid;
    end

    assign m0.ready  = ready_vec[0];
    assign m1.ready  = ready_vec[1];
    assign m0.rvalid = rvalid_vec[0];
    assign m1.rvalid = rvalid_vec[1];
    assign m0.rdata  = s.rdata;
    assign m1.rdata  = s.rdata;

endmodule

// File: tb/tb_iob_bus_arbiter.sv
// Randomised and directed bench for iob_bus_arbiter with a transaction-level reference model
// feeding an expected-event queue that a separate monitor drains.
`timescale 1ns/1ps
module tb_iob_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    logic cke;
    always #5 clk = ~clk;

    iob_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0 (), m1 (), s ();
    iob_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fm0 (), fm1 (), fs ();

    iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0)) dut (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .m0(m0), .m1(m1), .s(s)
    );

    iob_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(1)) dut_fp (
        .clk_i(clk), .rst_i(rst), .cke_i(cke), .m0(fm0), .m1(fm1), .s(fs)
    );

    // The fixed-priority instance sees exactly the same traffic.
    assign fm0.avalid = m0.avalid;
    assign fm0.addr   = m0.addr;
    assign fm0.wdata  = m0.wdata;
    assign fm0.wstrb  = m0.wstrb;
    assign fm1.avalid = m1.avalid;
    assign fm1.addr   = m1.addr;
    assign fm1.wdata  = m1.wdata;
    assign fm1.wstrb  = m1.wstrb;
    assign fs.rdata   = s.rdata;
    assign fs.rvalid  = s.rvalid;
    assign fs.ready   = s.ready;

    typedef struct {
        int          cyc;
        logic        s_avalid;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [3:0]  wstrb;
        logic [1:0]  ready;
        logic [1:0]  rvalid;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    bit   fp_phase = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: is a read outstanding, who owns it, who won last.
    bit md_reading;
    bit md_owner;
    bit md_last;
    bit ex_fwd;
    bit ex_w;
    bit ex_rd;

    // Inputs to apply on the next cycle.
    bit            n_rst, n_cke, n_srdy, n_srv;
    bit [1:0]      n_v;
    bit [AW-1:0]   n_a [2];
    bit [DW-1:0]   n_d [2];
    bit [3:0]      n_s [2];
    bit [DW-1:0]   n_srd;

    task automatic set_idle();
        n_rst = 0; n_cke = 1; n_srdy = 0; n_srv = 0; n_srd = '0; n_v = '0;
        for (int i = 0; i < 2; i++) begin
            n_a[i] = '0; n_d[i] = '0; n_s[i] = '0;
        end
    endtask

    task automatic req(input int m, input bit [AW-1:0] a, input bit [3:0] st, input bit [DW-1:0] d);
        n_v[m] = 1'b1; n_a[m] = a; n_s[m] = st; n_d[m] = d;
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            md_reading = 0; md_owner = 0; md_last = 1;
        end else if (cke) begin
            if (md_reading) begin
                if (s.rvalid) md_reading = 0;
            end else if (ex_fwd && s.ready) begin
                md_last = ex_w;
                if (ex_rd) begin
                    md_reading = 1; md_owner = ex_w;
                end
            end
        end
        #1;
        rst = n_rst; cke = n_cke;
        m0.avalid = n_v[0]; m0.addr = n_a[0]; m0.wdata = n_d[0]; m0.wstrb = n_s[0];
        m1.avalid = n_v[1]; m1.addr = n_a[1]; m1.wdata = n_d[1]; m1.wstrb = n_s[1];
        s.ready = n_srdy; s.rvalid = n_srv; s.rdata = n_srd;
        ex_fwd = 0; ex_w = 0;
        if (!md_reading) begin
            if (n_v == 2'b11) begin ex_fwd = 1; ex_w = !md_last; end
            else if (n_v[0]) begin ex_fwd = 1; ex_w = 0; end
            else if (n_v[1]) begin ex_fwd = 1; ex_w = 1; end
        end
        ex_rd = ex_fwd && (n_s[ex_w] == 4'h0);
        e.cyc      = cyc;
        e.s_avalid = ex_fwd;
        e.addr     = ex_fwd ? n_a[ex_w] : '0;
        e.wdata    = ex_fwd ? n_d[ex_w] : '0;
        e.wstrb    = ex_fwd ? n_s[ex_w] : '0;
        e.ready    = (ex_fwd && n_srdy) ? (ex_w ? 2'b10 : 2'b01) : 2'b00;
        e.rvalid   = (md_reading && n_srv) ? (md_owner ? 2'b10 : 2'b01) : 2'b00;
        e.rdata    = n_srd;
        if (ex_fwd || e.rvalid != 2'b00) exp_q.push_back(e);
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        logic       dut_any;
        logic [1:0] d_rdy, d_rv;
        d_rdy   = {m1.ready, m0.ready};
        d_rv    = {m1.rvalid, m0.rvalid};
        dut_any = s.avalid | (|d_rdy) | (|d_rv);
        if (dut_any) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output cyc=%0d avalid=%0b ready=%b rvalid=%b (required no activity)",
                         cyc, s.avalid, d_rdy, d_rv);
            end else begin
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.s_avalid != s.avalid || e.addr != s.addr || e.wdata != s.wdata ||
                    e.wstrb != s.wstrb || e.ready != d_rdy || e.rvalid != d_rv ||
                    (|d_rv && m0.rdata != e.rdata && d_rv[0]) || (|d_rv && m1.rdata != e.rdata && d_rv[1])) begin
                    failures++;
                    $display("FAIL txn cyc=%0d got avalid=%0b addr=%h wdata=%h wstrb=%h ready=%b rvalid=%b rdata=%h/%h; required cyc=%0d avalid=%0b addr=%h wdata=%h wstrb=%h ready=%b rvalid=%b rdata=%h",
                             cyc, s.avalid, s.addr, s.wdata, s.wstrb, d_rdy, d_rv, m0.rdata, m1.rdata,
                             e.cyc, e.s_avalid, e.addr, e.wdata, e.wstrb, e.ready, e.rvalid, e.rdata);
                end else begin
                    $display("txn cyc=%0d avalid=%0b addr=%h wstrb=%h ready=%b rvalid=%b rdata=%h",
                             cyc, s.avalid, s.addr, s.wstrb, d_rdy, d_rv, m0.rdata);
                end
            end
        end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_output cyc=%0d got nothing; required avalid=%0b addr=%h ready=%b rvalid=%b",
                     cyc, e.s_avalid, e.addr, e.ready, e.rvalid);
        end
        checks++;
        if (m0.rdata !== s.rdata || m1.rdata !== s.rdata) begin
            failures++;
            $display("FAIL rdata_pass cyc=%0d got %h/%h required %h", cyc, m0.rdata, m1.rdata, s.rdata);
        end
        if (m0.avalid === 1'b1) begin
            checks++;
            if (fm1.ready !== 1'b0) begin
                failures++;
                $display("FAIL fixed_prio_m1_ready cyc=%0d got %0b required 0", cyc, fm1.ready);
            end
        end
        if (fp_phase) begin
            checks++;
            if (fm0.ready !== 1'b1 || fs.addr !== m0.addr) begin
                failures++;
                $display("FAIL fixed_prio_m0_grant cyc=%0d got ready=%0b addr=%h required ready=1 addr=%h",
                         cyc, fm0.ready, fs.addr, m0.addr);
            end
        end
    end

    initial begin
        md_reading = 0; md_owner = 0; md_last = 1;
        ex_fwd = 0; ex_w = 0; ex_rd = 0;
        rst = 1; cke = 1;
        m0.avalid = 0; m0.addr = '0; m0.wdata = '0; m0.wstrb = '0;
        m1.avalid = 0; m1.addr = '0; m1.wdata = '0; m1.wstrb = '0;
        s.ready = 0; s.rvalid = 0; s.rdata = '0;

        set_idle(); n_rst = 1;
        step(); step();
        set_idle(); step();

        // Tie between two reads, first response 0xDEADBEEF while m1 waits.
        set_idle(); n_srdy = 1;
        req(0, 32'h100, 4'h0, '0); req(1, 32'h200, 4'h0, '0); step();
        set_idle(); n_srdy = 1; req(1, 32'h200, 4'h0, '0); step();
        set_idle(); n_srdy = 1; req(1, 32'h200, 4'h0, '0); n_srv = 1; n_srd = 32'hDEADBEEF; step();
        set_idle(); n_srdy = 1; req(1, 32'h200, 4'h0, '0); step();
        set_idle(); step();
        set_idle(); n_srv = 1; n_srd = 32'h12345678; step();
        set_idle(); step();

        // Back-to-back writes from m0.
        set_idle(); n_srdy = 1; req(0, 32'h10, 4'hF, 32'hA5A5_0001); step();
        set_idle(); n_srdy = 1; req(0, 32'h14, 4'hF, 32'hA5A5_0002); step();
        set_idle(); n_srdy = 1; req(0, 32'h18, 4'h3, 32'hA5A5_0003); step();

        // Reset while a read is outstanding, then a late rvalid.
        set_idle(); n_srdy = 1; req(0, 32'h300, 4'h0, '0); step();
        set_idle(); step();
        set_idle(); n_rst = 1; step();
        set_idle(); n_srv = 1; n_srd = 32'hBAD0BAD0; step();
        set_idle(); n_srdy = 1; req(1, 32'h40, 4'hF, 32'h1); step();

        // Clock enable low in RD_WAIT.
        set_idle(); n_srdy = 1; req(1, 32'h400, 4'h0, '0); step();
        for (int i = 0; i < 3; i++) begin
            set_idle(); n_cke = 0; step();
        end
        set_idle(); n_cke = 0; n_srv = 1; n_srd = 32'h0BADF00D; step();
        set_idle(); step();
        set_idle(); n_srv = 1; n_srd = 32'hCAFE0001; step();
        set_idle(); n_srdy = 1; req(0, 32'h44, 4'hF, 32'h2); step();

        // Both masters continuously writing; fixed-priority instance must always serve m0.
        set_idle(); n_rst = 1; step();
        for (int i = 0; i < 8; i++) begin
            set_idle(); n_srdy = 1;
            req(0, 32'h1000 + 32'(i * 4), 4'hF, 32'(i)); req(1, 32'h2000 + 32'(i * 4), 4'hF, 32'(i));
            step();
            fp_phase = 1'b1;
        end
        fp_phase = 1'b0;
        set_idle(); step();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            set_idle();
            n_rst  = ($urandom_range(0, 49) == 0);
            n_cke  = ($urandom_range(0, 7) != 0);
            n_srdy = $urandom_range(0, 1);
            n_srv  = ($urandom_range(0, 2) == 0);
            n_srd  = $urandom;
            for (int m = 0; m < 2; m++) begin
                if ($urandom_range(0, 1) == 1)
                    req(m, $urandom, ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0, $urandom);
            end
            step();
        end

        set_idle(); n_rst = 1; step();
        set_idle(); step(); step(); step();
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d pending required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
